// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pkg : shared types and constants for the spoc fetch stage         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned INST_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : synchronous {pc, inst} buffer with flush and free count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo
  import if_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] free_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign free_cnt = CW'(FIFO_DEPTH) - count_q;
  assign rdata    = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a full-buffer push needs.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage : spoc instruction fetch - PC, imem handshake, decode buffer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_stage
  import if_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   redir_pc, next_pc;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     free_cnt, free_after;
  logic [2*XLEN-1:0] fifo_rdata;
  logic              unused_bits;

  assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign next_pc     = redirect_valid ? redir_pc : pc_q;
  assign fifo_pop    = id_ready && !fifo_empty;
  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

  always_comb begin
    state_d   = state_q;
    pc_d      = next_pc;
    addr_d    = addr_q;
    kill_d    = kill_q;
    imem_req  = 1'b0;
    fifo_push = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redirect_valid;
    // The outstanding request already holds one slot, so the push is
    // charged against the current free count here.
    free_after = redirect_valid ? CW'(FIFO_DEPTH)
                                : free_cnt + CW'(fifo_pop) - CW'(fifo_push);
    case (state_q)
      S_IDLE: begin
        if (free_cnt != '0) begin
          state_d = S_REQ;
          addr_d  = next_pc;
          pc_d    = next_pc + XLEN'(INST_BYTES);
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          kill_d = 1'b1;
        end
        if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (free_after != '0) begin
            state_d = S_REQ;
            addr_d  = next_pc;
            pc_d    = next_pc + XLEN'(INST_BYTES);
          end else begin
            state_d = S_IDLE;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (2*XLEN)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .wdata    ({addr_q, imem_rdata}),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  assign imem_addr = addr_q;
  assign id_valid  = !fifo_empty;
  assign id_pc     = fifo_empty ? '0 : fifo_rdata[2*XLEN-1:XLEN];
  assign id_inst   = fifo_empty ? XLEN'(NOP_INST) : fifo_rdata[XLEN-1:0];

endmodule
`default_nettype wire
